sbs_stereo_splitter: RTL

//  Front-end of the stereo pipeline, directly upstream of the SGM disparity core.

---
 rtl/sbs_stereo_splitter.sv | 108 ++++++++++
 1 files changed

// File: rtl/sbs_stereo_splitter.sv
// Side-by-side stereo line splitter: buffers the left half of each SBS line and
// replays it in lockstep with the right half as aligned left/right pixel pairs.
module sbs_stereo_splitter #(
  parameter int HALF_IMG_WIDTH = 640,
  parameter int PIXEL_BITS     = 8,
  parameter int COL_WIDTH      = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  de_in,
  input  logic                  h_sync_in,
  input  logic                  v_sync_in,
  input  logic [PIXEL_BITS-1:0] pixel_in,
  output logic                  de_out,
  output logic                  h_sync_out,
  output logic                  v_sync_out,
  output logic                  pair_valid,
  output logic [PIXEL_BITS-1:0] pixel_left,
  output logic [PIXEL_BITS-1:0] pixel_right,
  output logic [COL_WIDTH-1:0]  col_out,
  output logic                  frame_err
);
  localparam int ADDR_BITS = (HALF_IMG_WIDTH > 1) ? $clog2(HALF_IMG_WIDTH) : 1;
  localparam logic [COL_WIDTH-1:0] HALF_COL  = COL_WIDTH'(HALF_IMG_WIDTH);
  localparam logic [COL_WIDTH-1:0] LAST_LEFT = COL_WIDTH'(HALF_IMG_WIDTH - 1);
  localparam logic [COL_WIDTH-1:0] LINE_END  = COL_WIDTH'(2 * HALF_IMG_WIDTH);

  typedef enum logic [2:0] {SYNC, IDLE, LEFT, RIGHT, OVERRUN} state_t;

  state_t                state;
  logic [COL_WIDTH-1:0]  col_cnt;
  logic [COL_WIDTH-1:0]  col;
  logic [COL_WIDTH-1:0]  rd_col;
  logic [ADDR_BITS-1:0]  wr_addr;
  logic [ADDR_BITS-1:0]  rd_addr;
  logic                  wr_en;
  logic                  rd_en;
  logic                  set_err;
  logic                  vs_rise;
  logic [PIXEL_BITS-1:0] line_ram [HALF_IMG_WIDTH];

  // col is the column of the pixel presented this cycle; col_cnt already holds it
  // while de_in is high and saturates at LINE_END to mark an overrun.
  always_comb begin
    col     = de_in ? col_cnt : '0;
    rd_col  = col - HALF_COL;
    wr_addr = col[ADDR_BITS-1:0];
    rd_addr = rd_col[ADDR_BITS-1:0];
    wr_en   = de_in && (state == IDLE || state == LEFT);
    rd_en   = de_in && (state == RIGHT) && (col < LINE_END);
    vs_rise = v_sync_in && !v_sync_out;
    set_err = 1'b0;
    case (state)
      LEFT:    set_err = !de_in;
      RIGHT:   set_err = de_in ? (col == LINE_END) : (col_cnt != LINE_END);
      OVERRUN: set_err = de_in;
      default: set_err = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr_en) line_ram[wr_addr] <= pixel_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= SYNC;
      col_cnt     <= '0;
      de_out      <= 1'b0;
      h_sync_out  <= 1'b0;
      v_sync_out  <= 1'b0;
      pair_valid  <= 1'b0;
      pixel_left  <= '0;
      pixel_right <= '0;
      col_out     <= '0;
      frame_err   <= 1'b0;
    end else begin
      de_out     <= de_in;
      h_sync_out <= h_sync_in;
      v_sync_out <= v_sync_in;
      col_out    <= col;
      pair_valid <= rd_en;
      if (!de_in)                 col_cnt <= '0;
      else if (col_cnt != LINE_END) col_cnt <= col_cnt + COL_WIDTH'(1);
      // The RAM read register doubles as the pixel_left output register.
      if (rd_en) begin
        pixel_left  <= line_ram[rd_addr];
        pixel_right <= pixel_in;
      end
      if (vs_rise)      frame_err <= 1'b0;
      else if (set_err) frame_err <= 1'b1;
      case (state)
        SYNC: if (!de_in) state <= IDLE;
        IDLE, LEFT: begin
          if (!de_in)                state <= IDLE;
          else if (col == LAST_LEFT) state <= RIGHT;
          else                       state <= LEFT;
        end
        RIGHT: begin
          if (!de_in)               state <= IDLE;
          else if (col == LINE_END) state <= OVERRUN;
        end
        OVERRUN: if (!de_in) state <= IDLE;
        default: state <= SYNC;
      endcase
    end
  end
endmodule
